// File: rtl/dct_pkg.sv
// Shared constants and state encoding for the bit-serial DA DCT sequencer.
// Holds the sample/ROM/result widths, the row/plane counter widths and the
// FSM state type used by da_dct_sequencer and da_shift_acc.
package dct_pkg;

  localparam int unsigned DATA_W    = 12;
  localparam int unsigned ROM_W     = 17;
  localparam int unsigned RES_W     = DATA_W + ROM_W + 1;
  localparam int unsigned NUM_SAMP  = 8;
  localparam int unsigned HALF_SAMP = NUM_SAMP / 2;
  localparam int unsigned ROW_W     = 3;
  localparam int unsigned PLANE_W   = 4;
  localparam int unsigned ROW_LAST  = 7;
  localparam int unsigned FRAC_BITS = 14;

  typedef enum logic [1:0] {
    ST_WAKE = 2'd0,
    ST_IDLE = 2'd1,
    ST_RUN  = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

endpackage

// File: rtl/da_shift_acc.sv
// Partial-sum adder and shift-accumulate register for one DA row.
// Ports:
//   clk, rst_n      : clock, async active-low reset
//   clr_i           : clear accumulator (block acceptance)
//   load_neg_i      : sign plane, acc = -partial
//   accumulate_i    : other planes, acc = 2*acc + partial
//   rom_lo_i/hi_i   : signed ROM words for samples 0-3 / 4-7
//   acc_next_c      : combinational next accumulator value
module da_shift_acc
  import dct_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_i,
  input  logic                    load_neg_i,
  input  logic                    accumulate_i,
  input  logic signed [ROM_W-1:0] rom_lo_i,
  input  logic signed [ROM_W-1:0] rom_hi_i,
  output logic signed [RES_W-1:0] acc_next_c
);

  logic signed [ROM_W:0]   partial;
  logic signed [RES_W-1:0] acc_q;
  logic signed [RES_W-1:0] acc_d;

  // Sign-extended sum of both ROM halves, then the plane update.
  always_comb begin
    partial = (ROM_W+1)'(rom_lo_i) + (ROM_W+1)'(rom_hi_i);
    acc_d   = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (load_neg_i) begin
      acc_d = -RES_W'(partial);
    end else if (accumulate_i) begin
      acc_d = (acc_q <<< 1) + RES_W'(partial);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_next_c = acc_d;

endmodule

// File: rtl/da_dct_sequencer.sv
// Bit-serial distributed-arithmetic sequencer for the 8-point DCT stage.
// Accepts a block of 8 signed samples, walks it one bit plane per cycle for
// each of the 8 rows, drives the ROM pair and emits one coefficient per row.
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   in_valid/in_ready/in_data  : sample block handshake (sample i at i*DATA_W)
//   rom_cs/rom_sel/rom_addr_*  : ROM bank control (row, plane bits)
//   rom_data_lo/hi             : combinational ROM outputs
//   out_valid/out_ready        : coefficient handshake
//   out_data/out_row           : coefficient and its row index
//   busy                       : block in progress (RUN or HOLD)
module da_dct_sequencer
  import dct_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_SAMP*DATA_W-1:0]   in_data,
  output logic                         rom_cs,
  output logic [ROW_W-1:0]             rom_sel,
  output logic [HALF_SAMP-1:0]         rom_addr_lo,
  output logic [HALF_SAMP-1:0]         rom_addr_hi,
  input  logic signed [ROM_W-1:0]      rom_data_lo,
  input  logic signed [ROM_W-1:0]      rom_data_hi,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [RES_W-1:0]             out_data,
  output logic [ROW_W-1:0]             out_row,
  output logic                         busy
);

  state_e                       state_q, state_d;
  logic [ROW_W-1:0]             row_q, row_d;
  logic [PLANE_W-1:0]           plane_q, plane_d;
  logic [NUM_SAMP*DATA_W-1:0]   samp_q, samp_d;

  logic                         in_ready_q, in_ready_d;
  logic                         rom_cs_q, rom_cs_d;
  logic [ROW_W-1:0]             rom_sel_q, rom_sel_d;
  logic [HALF_SAMP-1:0]         addr_lo_q, addr_lo_d;
  logic [HALF_SAMP-1:0]         addr_hi_q, addr_hi_d;
  logic                         out_valid_q, out_valid_d;
  logic [RES_W-1:0]             out_data_q, out_data_d;
  logic [ROW_W-1:0]             out_row_q, out_row_d;
  logic                         busy_q, busy_d;

  logic                         acc_clr, acc_load_neg, acc_accum;
  logic signed [RES_W-1:0]      acc_next;

  da_shift_acc u_acc (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (acc_clr),
    .load_neg_i   (acc_load_neg),
    .accumulate_i (acc_accum),
    .rom_lo_i     (rom_data_lo),
    .rom_hi_i     (rom_data_hi),
    .acc_next_c   (acc_next)
  );

  // State, counters, sample store and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_WAKE;
      row_q       <= '0;
      plane_q     <= '0;
      samp_q      <= '0;
      in_ready_q  <= 1'b0;
      rom_cs_q    <= 1'b0;
      rom_sel_q   <= '0;
      addr_lo_q   <= '0;
      addr_hi_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_row_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      plane_q     <= plane_d;
      samp_q      <= samp_d;
      in_ready_q  <= in_ready_d;
      rom_cs_q    <= rom_cs_d;
      rom_sel_q   <= rom_sel_d;
      addr_lo_q   <= addr_lo_d;
      addr_hi_q   <= addr_hi_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_row_q   <= out_row_d;
      busy_q      <= busy_d;
    end
  end

  // Next state, row/plane counters and accumulator controls.
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    plane_d      = plane_q;
    samp_d       = samp_q;
    acc_clr      = 1'b0;
    acc_load_neg = 1'b0;
    acc_accum    = 1'b0;
    unique case (state_q)
      ST_WAKE: state_d = ST_IDLE;
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          samp_d  = in_data;
          row_d   = '0;
          plane_d = PLANE_W'(DATA_W - 1);
          acc_clr = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (plane_q == PLANE_W'(DATA_W - 1)) begin
          acc_load_neg = 1'b1;
        end else begin
          acc_accum = 1'b1;
        end
        if (plane_q == '0) begin
          state_d = ST_HOLD;
        end else begin
          plane_d = plane_q - PLANE_W'(1);
        end
      end
      ST_HOLD: begin
        if (out_valid_q && out_ready) begin
          if (row_q == ROW_W'(ROW_LAST)) begin
            state_d = ST_IDLE;
          end else begin
            row_d   = row_q + ROW_W'(1);
            plane_d = PLANE_W'(DATA_W - 1);
            state_d = ST_RUN;
          end
        end
      end
    endcase
  end

  // Output values registered alongside the state; ROM controls follow the
  // upcoming state so the ROM sees its address in the RUN cycle itself.
  always_comb begin
    in_ready_d  = (state_d == ST_IDLE);
    busy_d      = (state_d == ST_RUN) || (state_d == ST_HOLD);
    rom_cs_d    = (state_d == ST_RUN);
    rom_sel_d   = rom_sel_q;
    addr_lo_d   = '0;
    addr_hi_d   = '0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_row_d   = out_row_q;
    if (state_d == ST_RUN) begin
      rom_sel_d = row_d;
      for (int i = 0; i < int'(HALF_SAMP); i++) begin
        addr_lo_d[i] = samp_d[i * int'(DATA_W) + int'(plane_d)];
        addr_hi_d[i] = samp_d[(i + int'(HALF_SAMP)) * int'(DATA_W) + int'(plane_d)];
      end
    end
    if (state_q == ST_RUN && plane_q == '0) begin
      out_valid_d = 1'b1;
      out_data_d  = acc_next;
      out_row_d   = row_q;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  assign in_ready    = in_ready_q;
  assign rom_cs      = rom_cs_q;
  assign rom_sel     = rom_sel_q;
  assign rom_addr_lo = addr_lo_q;
  assign rom_addr_hi = addr_hi_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_row     = out_row_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_da_dct_sequencer.sv
// Self-checking bench for da_dct_sequencer: a DCT-weight ROM model feeds the
// DUT and each coefficient is compared with sum_k x_k * w[row][k].
module tb_da_dct_sequencer;
  import dct_pkg::*;

  localparam int unsigned BW = NUM_SAMP * DATA_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [BW-1:0]     in_data;
  logic              rom_cs;
  logic [2:0]        rom_sel;
  logic [3:0]        rom_addr_lo, rom_addr_hi;
  logic signed [ROM_W-1:0] rom_data_lo, rom_data_hi;
  logic              out_valid;
  logic              out_ready;
  logic [RES_W-1:0]  out_data;
  logic [2:0]        out_row;
  logic              busy;

  int checks;
  int failures;

  logic [RES_W-1:0] obs_data [8];
  logic [2:0]       obs_row  [8];
  int               obs_lat  [8];
  bit               obs_to;

  da_dct_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .rom_cs      (rom_cs),
    .rom_sel     (rom_sel),
    .rom_addr_lo (rom_addr_lo),
    .rom_addr_hi (rom_addr_hi),
    .rom_data_lo (rom_data_lo),
    .rom_data_hi (rom_data_hi),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_row     (out_row),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // cos(m*pi/16) in Q.14
  function automatic int ctab(input int m);
    case (m)
      0: return 16384;
      1: return 16069;
      2: return 15137;
      3: return 13623;
      4: return 11585;
      5: return 9102;
      6: return 6270;
      7: return 3196;
      default: return 0;
    endcase
  endfunction

  // DCT weight of sample k in row r (row 0 uses c4).
  function automatic int wgt(input int r, input int k);
    int m;
    if (r == 0) return 11585;
    m = ((2 * k + 1) * r) % 32;
    if (m > 16) m = 32 - m;
    if (m > 8) return -ctab(16 - m);
    return ctab(m);
  endfunction

  function automatic longint ref_coef(input logic [BW-1:0] blk, input int r);
    longint s;
    logic signed [DATA_W-1:0] x;
    s = 0;
    for (int k = 0; k < 8; k++) begin
      x = blk[k*DATA_W +: DATA_W];
      s += longint'(x) * longint'(wgt(r, k));
    end
    return s;
  endfunction

  function automatic logic [BW-1:0] rand_blk();
    logic [BW-1:0] b;
    for (int k = 0; k < 8; k++) b[k*DATA_W +: DATA_W] = DATA_W'($urandom);
    return b;
  endfunction

  // ROM bank: each address bit adds the weight of its sample.
  int sum_lo, sum_hi;
  always_comb begin
    sum_lo = 0;
    sum_hi = 0;
    if (rom_cs) begin
      for (int k = 0; k < 4; k++) begin
        if (rom_addr_lo[k]) sum_lo += wgt(int'(rom_sel), k);
        if (rom_addr_hi[k]) sum_hi += wgt(int'(rom_sel), k + 4);
      end
    end
    rom_data_lo = ROM_W'(sum_lo);
    rom_data_hi = ROM_W'(sum_hi);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one block until accepted; returns at the cycle after acceptance.
  task automatic send_block(input logic [BW-1:0] blk, output bit to);
    int n;
    n = 0;
    to = 1'b0;
    in_data = blk;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) to = 1'b1;
    tick();
    in_valid = 1'b0;
    in_data = {$urandom, $urandom, $urandom};
  endtask

  // Gather all 8 row outputs with out_ready high; optionally present the
  // next block while row 7 is being handed over.
  task automatic collect_rows(input bit chain, input logic [BW-1:0] nxt);
    int n;
    obs_to = 1'b0;
    for (int r = 0; r < 8; r++) begin
      n = 0;
      while (!out_valid && n < 100) begin
        tick();
        n++;
      end
      if (!out_valid) obs_to = 1'b1;
      obs_lat[r]  = n;
      obs_data[r] = out_data;
      obs_row[r]  = out_row;
      if (r == 7 && chain) begin
        in_data  = nxt;
        in_valid = 1'b1;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({in_ready, rom_cs, rom_sel, rom_addr_lo, rom_addr_hi, out_valid, out_data, out_row, busy} !== 48'd0) begin
      failures++;
      $display("FAIL reset_values: got in_ready=%b rom_cs=%b out_valid=%b out_data=%0h busy=%b, want all 0",
               in_ready, rom_cs, out_valid, out_data, busy);
    end
    repeat (3) tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0 || rom_cs !== 1'b0) begin
      failures++;
      $display("FAIL wake_cycle: got in_ready=%b rom_cs=%b, want 0 0", in_ready, rom_cs);
    end
    tick();
    checks++;
    if (in_ready !== 1'b1 || rom_cs !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_wake: got in_ready=%b rom_cs=%b busy=%b, want 1 0 0", in_ready, rom_cs, busy);
    end
  endtask

  task automatic test_ones();
    logic [BW-1:0] blk;
    logic [RES_W-1:0] expv;
    bit to;
    for (int k = 0; k < 8; k++) blk[k*DATA_W +: DATA_W] = 12'h001;
    send_block(blk, to);
    collect_rows(1'b0, '0);
    checks++;
    if (to || obs_to) begin
      failures++;
      $display("FAIL ones_timeout: got accept_to=%b row_to=%b, want 0 0", to, obs_to);
    end
    checks++;
    if (obs_data[0] !== RES_W'(92680) || obs_row[0] !== 3'd0) begin
      failures++;
      $display("FAIL ones_row0: got data=%0d row=%0d, want 92680 0", $signed(obs_data[0]), obs_row[0]);
    end
    for (int r = 0; r < 8; r++) begin
      expv = RES_W'(ref_coef(blk, r));
      checks++;
      if (obs_data[r] !== expv || obs_row[r] !== 3'(r) || obs_lat[r] != int'(DATA_W)) begin
        failures++;
        $display("FAIL ones_row%0d: got data=%0d row=%0d lat=%0d, want %0d %0d %0d",
                 r, $signed(obs_data[r]), obs_row[r], obs_lat[r], $signed(expv), r, DATA_W);
      end
    end
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL ones_ready_after: got in_ready=%b busy=%b, want 1 0", in_ready, busy);
    end
  endtask

  task automatic test_neg_ones();
    logic [BW-1:0] blk;
    logic [RES_W-1:0] expv;
    bit to;
    blk = '1;
    send_block(blk, to);
    collect_rows(1'b0, '0);
    checks++;
    if (to || obs_to || obs_data[0] !== RES_W'(-92680)) begin
      failures++;
      $display("FAIL neg_ones_row0: got data=%0d to=%b/%b, want -92680", $signed(obs_data[0]), to, obs_to);
    end
    for (int r = 1; r < 8; r++) begin
      expv = RES_W'(ref_coef(blk, r));
      checks++;
      if (obs_data[r] !== expv || obs_row[r] !== 3'(r)) begin
        failures++;
        $display("FAIL neg_ones_row%0d: got data=%0d row=%0d, want %0d %0d",
                 r, $signed(obs_data[r]), obs_row[r], $signed(expv), r);
      end
    end
  endtask

  task automatic test_random();
    logic [BW-1:0] blk;
    logic [RES_W-1:0] expv;
    bit to;
    for (int b = 0; b < 4; b++) begin
      blk = rand_blk();
      if (b == 3) begin
        for (int k = 0; k < 8; k++) blk[k*DATA_W +: DATA_W] = (k % 2 == 0) ? 12'h800 : 12'h7FF;
      end
      send_block(blk, to);
      collect_rows(1'b0, '0);
      checks++;
      if (to || obs_to) begin
        failures++;
        $display("FAIL random_timeout blk%0d: got to=%b/%b, want 0 0", b, to, obs_to);
      end
      for (int r = 0; r < 8; r++) begin
        expv = RES_W'(ref_coef(blk, r));
        checks++;
        if (obs_data[r] !== expv || obs_row[r] !== 3'(r) || obs_lat[r] != int'(DATA_W)) begin
          failures++;
          $display("FAIL random blk%0d row%0d: got data=%0d row=%0d lat=%0d, want %0d %0d %0d",
                   b, r, $signed(obs_data[r]), obs_row[r], obs_lat[r], $signed(expv), r, DATA_W);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [BW-1:0] blk;
    logic [RES_W-1:0] expv, d;
    logic [2:0] rw;
    int n;
    bit to;
    blk = rand_blk();
    send_block(blk, to);
    for (int r = 0; r < 8; r++) begin
      n = 0;
      while (!out_valid && n < 100) begin
        tick();
        n++;
      end
      expv = RES_W'(ref_coef(blk, r));
      checks++;
      if (to || !out_valid || out_data !== expv || out_row !== 3'(r) || n != int'(DATA_W)) begin
        failures++;
        $display("FAIL stall row%0d: got valid=%b data=%0d row=%0d lat=%0d, want 1 %0d %0d %0d",
                 r, out_valid, $signed(out_data), out_row, n, $signed(expv), r, DATA_W);
      end
      if (r == 3) begin
        out_ready = 1'b0;
        d  = out_data;
        rw = out_row;
        for (int c = 0; c < 20; c++) begin
          tick();
          checks++;
          if (out_valid !== 1'b1 || out_data !== d || out_row !== rw || rom_cs !== 1'b0) begin
            failures++;
            $display("FAIL stall_hold cyc%0d: got valid=%b data=%0d row=%0d rom_cs=%b, want 1 %0d %0d 0",
                     c, out_valid, $signed(out_data), out_row, rom_cs, $signed(d), rw);
          end
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (rom_cs !== 1'b1 || rom_sel !== 3'd4) begin
          failures++;
          $display("FAIL stall_resume: got rom_cs=%b rom_sel=%0d, want 1 4", rom_cs, rom_sel);
        end
      end else begin
        tick();
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [BW-1:0] blk;
    logic [RES_W-1:0] expv;
    int n;
    bit to;
    blk = rand_blk();
    send_block(blk, to);
    for (int r = 0; r < 5; r++) begin
      n = 0;
      while (!out_valid && n < 100) begin
        tick();
        n++;
      end
      tick();
    end
    repeat (4) tick();
    checks++;
    if (rom_cs !== 1'b1 || rom_sel !== 3'd5 || busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_run_row5: got rom_cs=%b rom_sel=%0d busy=%b, want 1 5 1", rom_cs, rom_sel, busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, rom_cs, rom_sel, rom_addr_lo, rom_addr_hi, out_valid, out_data, out_row, busy} !== 48'd0) begin
      failures++;
      $display("FAIL async_reset: got in_ready=%b rom_cs=%b rom_sel=%0d out_valid=%b out_row=%0d busy=%b, want all 0",
               in_ready, rom_cs, rom_sel, out_valid, out_row, busy);
    end
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_wake: got in_ready=%b busy=%b, want 0 0", in_ready, busy);
    end
    blk = rand_blk();
    send_block(blk, to);
    collect_rows(1'b0, '0);
    checks++;
    if (to || obs_to) begin
      failures++;
      $display("FAIL reset_mid_timeout: got to=%b/%b, want 0 0", to, obs_to);
    end
    for (int r = 0; r < 8; r++) begin
      expv = RES_W'(ref_coef(blk, r));
      checks++;
      if (obs_data[r] !== expv || obs_row[r] !== 3'(r)) begin
        failures++;
        $display("FAIL reset_mid row%0d: got data=%0d row=%0d, want %0d %0d",
                 r, $signed(obs_data[r]), obs_row[r], $signed(expv), r);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [BW-1:0] b1, b2;
    logic [RES_W-1:0] expv;
    bit to;
    b1 = rand_blk();
    b2 = rand_blk();
    send_block(b1, to);
    collect_rows(1'b1, b2);
    checks++;
    if (to || obs_to || in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_gap: got in_ready=%b busy=%b to=%b/%b, want 1 0", in_ready, busy, to, obs_to);
    end
    for (int r = 0; r < 8; r++) begin
      expv = RES_W'(ref_coef(b1, r));
      checks++;
      if (obs_data[r] !== expv || obs_row[r] !== 3'(r)) begin
        failures++;
        $display("FAIL b2b blk1 row%0d: got %0d, want %0d", r, $signed(obs_data[r]), $signed(expv));
      end
    end
    tick();
    in_valid = 1'b0;
    in_data = {$urandom, $urandom, $urandom};
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1 || rom_cs !== 1'b1 || rom_sel !== 3'd0) begin
      failures++;
      $display("FAIL b2b_accept: got in_ready=%b busy=%b rom_cs=%b rom_sel=%0d, want 0 1 1 0",
               in_ready, busy, rom_cs, rom_sel);
    end
    collect_rows(1'b0, '0);
    for (int r = 0; r < 8; r++) begin
      expv = RES_W'(ref_coef(b2, r));
      checks++;
      if (obs_to || obs_data[r] !== expv || obs_row[r] !== 3'(r) || obs_lat[r] != int'(DATA_W)) begin
        failures++;
        $display("FAIL b2b blk2 row%0d: got data=%0d lat=%0d, want %0d %0d",
                 r, $signed(obs_data[r]), obs_lat[r], $signed(expv), DATA_W);
      end
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    test_reset();
    test_ones();
    test_neg_ones();
    test_random();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
